// File: rtl/spi_regs_pkg.sv
// spi_regs_pkg: register map constants shared by the SPI device register file
package spi_regs_pkg;
    localparam int REG_CTRL          = 0;
    localparam int REG_DUMMY         = 1;
    localparam int REG_WRAP_LO       = 2;
    localparam int REG_WRAP_HI       = 3;
    localparam int CTRL_QPI_BIT      = 0;
    localparam int CTRL_LOCK_BIT     = 7;
    localparam int DUMMY_RST_DEFAULT = 32;
endpackage

// File: rtl/spi_sat_counter.sv
// spi_sat_counter: up-counter that holds at all-ones, synchronous clear
module spi_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             sclk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);
    always_ff @(posedge sclk)
        value <= clr ? '0 : (inc && value != '1) ? value + WIDTH'(1) : value;
endmodule

// File: rtl/spi_device_regfile.sv
// spi_device_regfile: shadow/live SPI config registers with write-lock and error strobe.
// SPI_REGS_ERRCNT_EN turns the top address into a read-only saturating reject counter.
module spi_device_regfile
    import spi_regs_pkg::*;
#(
    parameter int REG_SIZE  = 8,
    parameter int NUM_REGS  = 8,
    parameter int DUMMY_RST = DUMMY_RST_DEFAULT,
    parameter int AW        = $clog2(NUM_REGS)
) (
    input  logic                sclk,
    input  logic                rstn,
    input  logic [REG_SIZE-1:0] wr_data,
    input  logic [AW-1:0]       wr_addr,
    input  logic                wr_data_valid,
    input  logic [AW-1:0]       rd_addr,
    output logic [REG_SIZE-1:0] rd_data,
    input  logic                commit,
    output logic                en_qpi,
    output logic [7:0]          dummy_cycles,
    output logic [15:0]         wrap_length,
    output logic                locked,
    output logic                wr_err
);
`ifdef SPI_REGS_ERRCNT_EN
    localparam bit ERRCNT = 1'b1;
`else
    localparam bit ERRCNT = 1'b0;
`endif
    logic [REG_SIZE-1:0] shadow [NUM_REGS];
    logic                we;
    logic [REG_SIZE-1:0] ctrl_nxt, dummy_nxt, lo_nxt, hi_nxt;

    function automatic logic [REG_SIZE-1:0] shadow_nxt(input int k);
        return (we && int'(wr_addr) == k) ? wr_data : shadow[k];
    endfunction

    assign locked = shadow[REG_CTRL][CTRL_LOCK_BIT];
    assign we     = wr_data_valid && int'(wr_addr) < NUM_REGS && !locked &&
                    !(ERRCNT && int'(wr_addr) == NUM_REGS - 1);

`ifdef SPI_REGS_ERRCNT_EN
    logic [7:0] err_cnt;
    spi_sat_counter #(.WIDTH(8)) u_err_cnt (
        .sclk  (sclk),
        .clr   (!rstn),
        .inc   (wr_err),
        .value (err_cnt)
    );
    assign rd_data = int'(rd_addr) == NUM_REGS - 1 ? REG_SIZE'(err_cnt) :
                     int'(rd_addr) < NUM_REGS ? shadow[rd_addr] : '0;
`else
    assign rd_data = int'(rd_addr) < NUM_REGS ? shadow[rd_addr] : '0;
`endif

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (!ERRCNT || i != NUM_REGS - 1) begin : g_rw
            logic [REG_SIZE-1:0] q;
            always_ff @(posedge sclk)
                q <= !rstn ? (i == REG_DUMMY ? REG_SIZE'(DUMMY_RST) : '0) : shadow_nxt(i);
            assign shadow[i] = q;
        end else begin : g_ro
            assign shadow[i] = '0;
        end
    end

    // commit samples shadow-next so a same-cycle write reaches the live outputs
    assign ctrl_nxt  = shadow_nxt(REG_CTRL);
    assign dummy_nxt = shadow_nxt(REG_DUMMY);
    assign lo_nxt    = shadow_nxt(REG_WRAP_LO);
    assign hi_nxt    = shadow_nxt(REG_WRAP_HI);

    always_ff @(posedge sclk) begin
        if (!rstn) begin
            en_qpi       <= 1'b0;
            dummy_cycles <= 8'(DUMMY_RST);
            wrap_length  <= '0;
            wr_err       <= 1'b0;
        end else begin
            wr_err <= wr_data_valid && !we;
            if (commit) begin
                en_qpi       <= ctrl_nxt[CTRL_QPI_BIT];
                dummy_cycles <= dummy_nxt[7:0];
                wrap_length  <= {hi_nxt[7:0], lo_nxt[7:0]};
            end
        end
    end
endmodule

// File: tb/tb_spi_device_regfile.sv
// tb_spi_device_regfile: directed map checks plus randomized traffic against a register-map model
module tb_spi_device_regfile;
    localparam int RS = 12;
    localparam int N  = 6;
    localparam int AW = $clog2(N);
`ifdef SPI_REGS_ERRCNT_EN
    localparam bit ERRCNT = 1'b1;
`else
    localparam bit ERRCNT = 1'b0;
`endif

    logic          sclk = 1'b0;
    logic          rstn = 1'b0;
    logic          wr_data_valid = 1'b0;
    logic          commit = 1'b0;
    logic [RS-1:0] wr_data = '0;
    logic [AW-1:0] wr_addr = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [RS-1:0] rd_data;
    logic          en_qpi, locked, wr_err;
    logic [7:0]    dummy_cycles;
    logic [15:0]   wrap_length;

    spi_device_regfile #(.REG_SIZE(RS), .NUM_REGS(N), .DUMMY_RST(32)) dut (
        .sclk          (sclk),
        .rstn          (rstn),
        .wr_data       (wr_data),
        .wr_addr       (wr_addr),
        .wr_data_valid (wr_data_valid),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .commit        (commit),
        .en_qpi        (en_qpi),
        .dummy_cycles  (dummy_cycles),
        .wrap_length   (wrap_length),
        .locked        (locked),
        .wr_err        (wr_err)
    );

    always #5 sclk = ~sclk;

    int compared = 0;
    int mismatched = 0;

    // register-map model: what software would see after each clock edge
    logic [RS-1:0] sh [N];
    logic          m_en, m_err, m_acc;
    logic [7:0]    m_dummy, m_cnt;
    logic [15:0]   m_wrap;
    bit            live = 0;

    always @(posedge sclk) begin
        if (!rstn) begin
            foreach (sh[i]) sh[i] = '0;
            sh[1] = RS'(32);
            m_en = 0; m_dummy = 8'd32; m_wrap = 0; m_err = 0; m_cnt = 0;
            live = 1;
        end else begin
            m_acc = wr_data_valid && int'(wr_addr) < N && !sh[0][7] &&
                    !(ERRCNT && int'(wr_addr) == N - 1);
            if (m_err && m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
            m_err = wr_data_valid && !m_acc;
            if (m_acc) sh[wr_addr] = wr_data;
            if (commit) begin
                m_en    = sh[0][0];
                m_dummy = sh[1][7:0];
                m_wrap  = {sh[3][7:0], sh[2][7:0]};
            end
        end
    end

    function automatic logic [RS-1:0] m_read(input logic [AW-1:0] a);
        if (int'(a) >= N) return '0;
        if (ERRCNT && int'(a) == N - 1) return RS'(m_cnt);
        return sh[a];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge sclk) if (live) begin
        chk("rd_data", 32'(rd_data), 32'(m_read(rd_addr)));
        chk("en_qpi", 32'(en_qpi), 32'(m_en));
        chk("dummy_cycles", 32'(dummy_cycles), 32'(m_dummy));
        chk("wrap_length", 32'(wrap_length), 32'(m_wrap));
        chk("locked", 32'(locked), 32'(sh[0][7]));
        chk("wr_err", 32'(wr_err), 32'(m_err));
    end

    task automatic cyc(input logic v, input int a, input int d, input logic c, input logic r);
        wr_data_valid = v; wr_addr = AW'(a); wr_data = RS'(d); commit = c; rstn = r;
        @(posedge sclk); #1;
        wr_data_valid = 0; commit = 0; rstn = 1;
    endtask

    task automatic rd(input int a, input string nm, input int exp);
        rd_addr = AW'(a); #1;
        chk(nm, 32'(rd_data), exp);
    endtask

    int a, d;

    initial begin
        cyc(0, 0, 0, 0, 0);
        rd(1, "t1_rd1", 32);
        chk("t1_en", 32'(en_qpi), 0);
        chk("t1_dummy", 32'(dummy_cycles), 32);
        chk("t1_wrap", 32'(wrap_length), 0);
        chk("t1_locked", 32'(locked), 0);
        chk("t1_err", 32'(wr_err), 0);

        cyc(1, 0, 'h01, 0, 1);
        cyc(1, 1, 'h08, 0, 1);
        cyc(1, 2, 'h40, 0, 1);
        cyc(1, 3, 'h01, 0, 1);
        rd(2, "t2_rd2", 'h40);
        rd(1, "t2_rd1", 'h08);
        chk("t2_en_pre", 32'(en_qpi), 0);
        chk("t2_dummy_pre", 32'(dummy_cycles), 32);
        chk("t2_wrap_pre", 32'(wrap_length), 0);
        cyc(0, 0, 0, 1, 1);
        chk("t2_en", 32'(en_qpi), 1);
        chk("t2_dummy", 32'(dummy_cycles), 8);
        chk("t2_wrap", 32'(wrap_length), 'h0140);

        cyc(1, 1, 'h10, 1, 1);
        chk("t3_dummy", 32'(dummy_cycles), 16);

        cyc(1, 0, 'h181, 0, 1);
        chk("t4_locked", 32'(locked), 1);
        chk("t4_err_lockwr", 32'(wr_err), 0);
        cyc(1, 1, 'h04, 0, 1);
        chk("t4_err", 32'(wr_err), 1);
        rd(1, "t4_rd1", 'h10);
        rd(0, "t4_rd0", 'h181);
        cyc(0, 0, 0, 0, 1);
        chk("t4_err_once", 32'(wr_err), 0);
        cyc(0, 0, 0, 0, 0);
        chk("t4_unlock", 32'(locked), 0);
        chk("t4_rst_dummy", 32'(dummy_cycles), 32);

        cyc(1, 7, 'h55, 0, 1);
        chk("t5_err", 32'(wr_err), 1);
        rd(7, "t5_rd7", 0);
        rd(1, "t5_rd1", 32);

`ifdef SPI_REGS_ERRCNT_EN
        cyc(0, 0, 0, 0, 0);
        repeat (300) cyc(1, 7, 1, 0, 1);
        cyc(0, 0, 0, 0, 1);
        rd(N - 1, "t6_sat", 255);
        cyc(1, N - 1, 3, 0, 1);
        chk("t6_err", 32'(wr_err), 1);
        rd(N - 1, "t6_hold", 255);
        cyc(0, 0, 0, 0, 0);
        rd(N - 1, "t6_clr", 0);
`else
        cyc(1, N - 1, 'hABC, 0, 1);
        rd(N - 1, "t6_scratch", 'hABC);
`endif

        repeat (3000) begin
            a = $urandom_range(0, 7);
            d = int'($urandom_range(0, (1 << RS) - 1));
            if (a == 0 && $urandom_range(0, 15) != 0) d = d & ~'h80;
            rd_addr = AW'($urandom_range(0, 7));
            cyc($urandom_range(0, 2) != 0, a, d, $urandom_range(0, 5) == 0,
                $urandom_range(0, 60) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
